// File: rtl/rate_div_pkg.sv
// Shared types and constants for the multi-channel rate divider.
package rate_div_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  // One second at a 50 MHz system clock (period = delay + 1 cycles).
  localparam int unsigned DEFAULT_DELAY_1HZ = 32'd49_999_999;

endpackage

// File: rtl/rate_div_chan.sv
// One divider channel: down-counter with reload, programmable period and
// strobe / square-wave output.
module rate_div_chan
  import rate_div_pkg::*;
#(
  parameter int unsigned WIDTH         = 27,
  parameter int unsigned DEFAULT_DELAY = DEFAULT_DELAY_1HZ
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             active,
  input  logic             wr,
  input  logic             restart,
  input  logic [WIDTH-1:0] delay,
  input  mode_e            mode,
  output logic             tick,
  output logic             wrap
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] delay_r;
  logic [WIDTH-1:0] delay_nxt;
  mode_e            mode_r;
  mode_e            mode_nxt;
  logic             tick_nxt;
  logic             wrap_nxt;

  // Next-state: a same-cycle write is visible to the reload; restart wins over all.
  always_comb begin
    delay_nxt = delay_r;
    mode_nxt  = mode_r;
    q_nxt     = q;
    tick_nxt  = tick;
    wrap_nxt  = 1'b0;

    if (wr) begin
      delay_nxt = delay;
      mode_nxt  = mode;
    end

    if (active) begin
      if (q == '0) begin
        q_nxt    = delay_nxt;
        wrap_nxt = 1'b1;
        tick_nxt = (mode_nxt == MODE_PULSE) ? 1'b1 : ~tick;
      end else begin
        q_nxt = q - WIDTH'(1);
        if (mode_nxt == MODE_PULSE) tick_nxt = 1'b0;
      end
    end else if (mode_nxt == MODE_PULSE) begin
      tick_nxt = 1'b0;
    end

    // A mode switch restarts the output waveform from low.
    if (wr && (mode != mode_r)) tick_nxt = 1'b0;

    if (wr && restart) begin
      q_nxt    = delay;
      wrap_nxt = 1'b0;
      tick_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= WIDTH'(DEFAULT_DELAY);
      delay_r <= WIDTH'(DEFAULT_DELAY);
      mode_r  <= MODE_PULSE;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      q       <= q_nxt;
      delay_r <= delay_nxt;
      mode_r  <= mode_nxt;
      tick    <= tick_nxt;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: rtl/rate_divider_multi.sv
// NUM_CH independent programmable timebases sharing one clock and one
// configuration write port.
module rate_divider_multi
  import rate_div_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned WIDTH         = 27,
  parameter int unsigned DEFAULT_DELAY = DEFAULT_DELAY_1HZ,
  parameter int unsigned CH_IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [WIDTH-1:0]    cfg_delay,
  input  logic                cfg_mode,
  input  logic                cfg_restart,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   wrap
);

  // Compared at 32 bits so out-of-range channel numbers never alias a real channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;

    assign wr_sel = cfg_we && (32'(cfg_ch) == 32'(i));

    rate_div_chan #(
      .WIDTH         (WIDTH),
      .DEFAULT_DELAY (DEFAULT_DELAY)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .active  (run & ch_en[i]),
      .wr      (wr_sel),
      .restart (cfg_restart),
      .delay   (cfg_delay),
      .mode    (mode_e'(cfg_mode)),
      .tick    (tick[i]),
      .wrap    (wrap[i])
    );
  end

endmodule
